// File: rtl/dmem_ctrl.sv
// Data-memory responder: turns one load/store from the core into a single
// valid/ready bus word transfer, with lane steering, load extension and error flags.
module dmem_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [2:0]  i_Funct3,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_WData,
  output logic [31:0] o_RData,
  output logic        o_Stall,
  output logic        o_Done,
  output logic        o_AccessErr,
  output logic        o_Timeout,
  output logic        o_BusValid,
  output logic        o_BusWrite,
  output logic [31:0] o_BusAddr,
  output logic [31:0] o_BusWData,
  output logic [3:0]  o_BusBE,
  input  logic        i_BusReady,
  input  logic [31:0] i_BusRData
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             write_q, write_d;
  logic             tmo_q, tmo_d;

  logic        req;
  logic        f3_legal;
  logic        misaligned;
  logic        req_err;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] shifted;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_ext;

  assign req = i_MemRead | i_MemWrite;

  // Unsigned sizes (BU/HU) only make sense for loads.
  always_comb begin
    f3_legal = 1'b0;
    case (i_Funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~i_MemWrite;
      default:                f3_legal = 1'b0;
    endcase
  end

  assign misaligned = ((i_Funct3[1:0] == 2'b01) & i_Addr[0]) |
                      ((i_Funct3[1:0] == 2'b10) & (i_Addr[1:0] != 2'b00));
  assign req_err    = (i_MemRead & i_MemWrite) | ~f3_legal | misaligned;

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = i_WData;
    case (i_Funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << i_Addr[1:0];
        wdata_new = {4{i_WData[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << i_Addr[1:0];
        wdata_new = {2{i_WData[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = i_WData;
      end
    endcase
  end

  assign shifted = i_BusRData >> {off_q, 3'b000};
  assign rbyte   = shifted[7:0];
  assign rhalf   = off_q[1] ? i_BusRData[31:16] : i_BusRData[15:0];

  always_comb begin
    load_ext = i_BusRData;
    case (f3_q)
      3'b000:  load_ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_ext = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_ext = {24'd0, rbyte};
      3'b101:  load_ext = {16'd0, rhalf};
      default: load_ext = i_BusRData;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    off_d   = off_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    write_d = write_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (req_err) begin
            state_d = S_ERR;
            tmo_d   = 1'b0;
            rdata_d = '0;
          end else begin
            state_d = S_BUS;
            cnt_d   = '0;
            addr_d  = {i_Addr[31:2], 2'b00};
            off_d   = i_Addr[1:0];
            f3_d    = i_Funct3;
            wdata_d = wdata_new;
            be_d    = be_new;
            write_d = i_MemWrite;
          end
        end
      end
      S_BUS: begin
        // A ready seen in the final allowed cycle still completes normally.
        if (i_BusReady) begin
          state_d = S_DONE;
          if (!write_q) rdata_d = load_ext;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERR;
          tmo_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      write_q <= write_d;
      tmo_q   <= tmo_d;
    end
  end

  // Stall is gated by reset so the core is released the instant reset lands.
  assign o_Stall     = i_rst_n & req & ((state_q == S_IDLE) | (state_q == S_BUS));
  assign o_Done      = (state_q == S_DONE) | (state_q == S_ERR);
  assign o_AccessErr = (state_q == S_ERR) & ~tmo_q;
  assign o_Timeout   = (state_q == S_ERR) & tmo_q;
  assign o_BusValid  = (state_q == S_BUS);
  assign o_BusWrite  = write_q;
  assign o_BusAddr   = addr_q;
  assign o_BusWData  = wdata_q;
  assign o_BusBE     = be_q;
  assign o_RData     = rdata_q;

endmodule
